// File: rtl/router_pkg.sv
// Shared types and header layout for the router packet transmitter.
package router_pkg;

    localparam int MAX_LEN   = 63;
    localparam int ADDR_W    = 2;
    localparam int LEN_W     = 6;
    localparam int BYTE_W    = 8;
    localparam int BUF_DEPTH = 64;
    localparam int BUF_AW    = 6;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } tx_state_t;

    function automatic logic [BYTE_W-1:0] make_header(input logic [ADDR_W-1:0] addr,
                                                      input logic [LEN_W-1:0]  len);
        logic [BYTE_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        return hdr;
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: 64x8 register array, synchronous write, combinational read, no reset.
module router_tx_buf
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              wr_en,
    input  logic [BUF_AW-1:0] wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [BUF_AW-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] r_mem [BUF_DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter: buffers a payload, then sends header/payload/parity.
// Optional ROUTER_TX_PARITY_INJECT_EN adds inject_err to invert the transmitted parity byte.
module router_pkt_tx #(
    parameter int MAX_LEN = 63,
    parameter int DATA_W  = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_addr,
    input  logic [5:0]        req_len,
    output logic              req_err,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              tx_done
`ifdef ROUTER_TX_PARITY_INJECT_EN
    ,
    input  logic              inject_err
`endif
);
    import router_pkg::*;

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic              r_alive;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_parity;
    logic              r_pkt_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_tx_done;
    logic              r_req_err;

    logic              w_pkt_valid_next;
    logic [DATA_W-1:0] w_data_next;
    logic              w_req_fire;
    logic              w_req_bad;
    logic              w_pl_fire;
    logic              w_last_idx;
    logic [BUF_AW-1:0] w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_par_mask;

    // r_alive keeps req_ready low until the first edge after reset release.
    assign req_ready  = r_alive && (r_state == ST_IDLE);
    assign pl_ready   = (r_state == ST_FILL);
    assign w_req_fire = req_valid && req_ready;
    assign w_req_bad  = (req_addr == ADDR_INVALID) || (req_len == '0) || (int'(req_len) > MAX_LEN);
    assign w_pl_fire  = pl_valid && pl_ready;
    assign w_last_idx = (r_idx == r_len - LEN_W'(1));

    assign pkt_valid = r_pkt_valid;
    assign data_out  = r_data;
    assign tx_done   = r_tx_done;
    assign req_err   = r_req_err;

`ifdef ROUTER_TX_PARITY_INJECT_EN
    logic r_inject;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_inject <= 1'b0;
        end else if (w_req_fire) begin
            r_inject <= inject_err;
        end
    end

    assign w_par_mask = {DATA_W{r_inject}};
`else
    assign w_par_mask = '0;
`endif

    router_tx_buf u_buf (
        .clock   (clock),
        .wr_en   (w_pl_fire),
        .wr_addr (r_idx),
        .wr_data (pl_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Bus outputs are registered, so they are computed here for the state being entered.
    always_comb begin
        w_state_next     = r_state;
        w_pkt_valid_next = r_pkt_valid;
        w_data_next      = r_data;
        w_rd_addr        = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req_fire && !w_req_bad) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_pl_fire && w_last_idx) begin
                    w_state_next     = ST_HEADER;
                    w_pkt_valid_next = 1'b1;
                    w_data_next      = make_header(r_addr, r_len);
                end
            end
            ST_HEADER: begin
                if (!busy) begin
                    w_state_next = ST_PAYLOAD;
                    w_data_next  = w_rd_data;
                end
            end
            ST_PAYLOAD: begin
                w_rd_addr = r_idx + BUF_AW'(1);
                if (!busy) begin
                    if (w_last_idx) begin
                        w_state_next     = ST_PARITY;
                        w_pkt_valid_next = 1'b0;
                        w_data_next      = r_parity ^ w_par_mask;
                    end else begin
                        w_data_next = w_rd_data;
                    end
                end
            end
            ST_PARITY: begin
                if (!busy) begin
                    w_state_next = ST_GAP;
                    w_data_next  = '0;
                end
            end
            ST_GAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next     = ST_IDLE;
                w_pkt_valid_next = 1'b0;
                w_data_next      = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_alive     <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_parity    <= '0;
            r_pkt_valid <= 1'b0;
            r_data      <= '0;
            r_tx_done   <= 1'b0;
            r_req_err   <= 1'b0;
        end else begin
            r_alive     <= 1'b1;
            r_pkt_valid <= w_pkt_valid_next;
            r_data      <= w_data_next;
            r_tx_done   <= (r_state == ST_PARITY) && !busy;
            r_req_err   <= w_req_fire && w_req_bad;

            if (w_req_fire) begin
                r_addr <= req_addr;
                r_len  <= req_len;
                r_idx  <= '0;
                if (!w_req_bad) begin
                    r_parity <= make_header(req_addr, req_len);
                end
            end

            // idx is reused: write pointer while filling, read pointer while sending.
            if (w_pl_fire) begin
                r_parity <= r_parity ^ pl_data;
                r_idx    <= w_last_idx ? '0 : r_idx + LEN_W'(1);
            end

            if ((r_state == ST_PAYLOAD) && !busy) begin
                r_idx <= w_last_idx ? '0 : r_idx + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomised scoreboard bench for router_pkt_tx; the model predicts the bus byte stream per request.
module tb_router_pkt_tx;

    localparam logic [7:0] K_V    = 8'd1;
    localparam logic [7:0] K_PAR  = 8'd2;
    localparam logic [7:0] K_DONE = 8'd3;
    localparam logic [7:0] K_ERR  = 8'd4;

    typedef struct packed {
        logic [7:0] kind;
        logic [7:0] data;
    } exp_t;

    logic       clock;
    logic       resetn;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       req_err;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic       inject_err;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] pay [64];
    bit         busy_rand   = 0;
    bit         stall_armed = 0;
    int         stall_left  = 0;
    int         pl_gap_pct  = 0;

    router_pkt_tx dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_err    (req_err),
        .pl_valid   (pl_valid),
        .pl_ready   (pl_ready),
        .pl_data    (pl_data),
        .busy       (busy),
        .pkt_valid  (pkt_valid),
        .data_out   (data_out),
        .tx_done    (tx_done)
`ifdef ROUTER_TX_PARITY_INJECT_EN
        ,
        .inject_err (inject_err)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input string name, input logic [7:0] kind, input logic [7:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_unexpected"}, {16'h0, kind, data}, 32'h0);
        end else begin
            e = sb.pop_front();
            check(name, {16'h0, kind, data}, {16'h0, e.kind, e.data});
        end
    endtask

    // Busy generator: optional one-shot 4-cycle stall on byte 0x22, else random or idle.
    initial begin
        busy = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (stall_armed && pkt_valid && data_out == 8'h22) begin
                busy        = 1'b1;
                stall_left  = 3;
                stall_armed = 0;
            end else if (stall_left > 0) begin
                busy = 1'b1;
                stall_left--;
            end else begin
                busy = busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
    end

    // Monitor: pops the expected stream whenever the bus moves or a pulse appears.
    initial begin
        bit         in_pkt;
        bit         want_done;
        bit         stalled;
        logic [7:0] prev_data;
        logic       prev_pv;
        in_pkt    = 0;
        want_done = 0;
        stalled   = 0;
        prev_data = 8'h00;
        prev_pv   = 1'b0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                in_pkt    = 0;
                want_done = 0;
                stalled   = 0;
            end else begin
                if (stalled) begin
                    check("hold_data", {24'h0, data_out}, {24'h0, prev_data});
                    check("hold_valid", {31'h0, pkt_valid}, {31'h0, prev_pv});
                end
                stalled   = busy && (pkt_valid || in_pkt);
                prev_data = data_out;
                prev_pv   = pkt_valid;
                if (want_done) begin
                    check("gap_cycle", {22'h0, tx_done, pkt_valid, data_out}, {22'h0, 1'b1, 1'b0, 8'h00});
                    pop_check("done", K_DONE, 8'h00);
                    want_done = 0;
                end else if (tx_done) begin
                    check("spurious_tx_done", {31'h0, tx_done}, 32'h0);
                end
                if (req_err) begin
                    pop_check("req_err", K_ERR, 8'h00);
                end
                if (pkt_valid) begin
                    in_pkt = 1;
                    if (!busy) pop_check("bus_byte", K_V, data_out);
                end else if (in_pkt && !busy) begin
                    pop_check("parity", K_PAR, data_out);
                    in_pkt    = 0;
                    want_done = 1;
                end
            end
        end
    end

    // Reference model: header = len*4 + addr, then payload, then XOR of everything sent.
    task automatic send(input logic [1:0] a, input logic [5:0] l, input bit inj);
        logic [7:0] par;
        logic [7:0] hdr;
        bit         inj_eff;
        bit         bad;
        int         guard;
`ifdef ROUTER_TX_PARITY_INJECT_EN
        inj_eff = inj;
`else
        inj_eff = 0;
`endif
        bad = (a == 2'd3) || (l == 6'd0);
        $display("pkt addr=%0d len=%0d inject=%0d %s", a, l, inj_eff, bad ? "reject" : "send");
        if (bad) begin
            sb.push_back(exp_t'{K_ERR, 8'h00});
        end else begin
            hdr = 8'(int'(l) * 4 + int'(a));
            par = hdr;
            sb.push_back(exp_t'{K_V, hdr});
            for (int i = 0; i < int'(l); i++) begin
                sb.push_back(exp_t'{K_V, pay[i]});
                par = par ^ pay[i];
            end
            sb.push_back(exp_t'{K_PAR, inj_eff ? ~par : par});
            sb.push_back(exp_t'{K_DONE, 8'h00});
        end

        req_addr   = a;
        req_len    = l;
        inject_err = inj;
        req_valid  = 1'b1;
        guard      = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!req_ready && guard < 2000);
        check("req_ready_wait", {31'h0, req_ready}, 32'h1);
        @(posedge clock);
        #1;
        req_valid  = 1'b0;
        req_addr   = 2'($urandom);
        req_len    = 6'($urandom);
        inject_err = 1'($urandom);

        if (!bad) begin
            guard = 0;
            for (int i = 0; i < int'(l); ) begin
                if ($urandom_range(0, 99) < pl_gap_pct) begin
                    pl_valid = 1'b0;
                    pl_data  = 8'($urandom);
                end else begin
                    pl_valid = 1'b1;
                    pl_data  = pay[i];
                end
                @(negedge clock);
                guard++;
                if (pl_valid && pl_ready) i++;
                if (guard > 3000) begin
                    check("fill_progress", {31'h0, pl_ready}, 32'h1);
                    break;
                end
                @(posedge clock);
                #1;
            end
            pl_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 3000) begin
            @(negedge clock);
            guard++;
        end
        check({name, "_drained"}, sb.size(), 32'h0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int guard;
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 2'd0;
        req_len    = 6'd0;
        pl_valid   = 1'b0;
        pl_data    = 8'h00;
        inject_err = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_pl_ready", {31'h0, pl_ready}, 32'h0);
        check("rst_pkt_valid", {31'h0, pkt_valid}, 32'h0);
        check("rst_data_out", {24'h0, data_out}, 32'h0);
        check("rst_tx_done", {31'h0, tx_done}, 32'h0);
        check("rst_req_err", {31'h0, req_err}, 32'h0);
        @(posedge clock);
        #2;
        resetn = 1'b1;
        @(negedge clock);
        check("req_ready_pre_edge", {31'h0, req_ready}, 32'h0);
        @(negedge clock);
        check("req_ready_post_release", {31'h0, req_ready}, 32'h1);
        check("pkt_valid_post_release", {31'h0, pkt_valid}, 32'h0);
        @(posedge clock);
        #1;

        // Basic packet: 0x0D, 11, 22, 33, parity 0x0D.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send(2'd1, 6'd3, 1'b0);
        wait_idle("basic");

        // Same packet with a 4-cycle stall while 0x22 is on the bus.
        stall_armed = 1;
        send(2'd1, 6'd3, 1'b0);
        wait_idle("stall");
        check("stall_seen", {31'h0, stall_armed}, 32'h0);

        // Rejections.
        send(2'd3, 6'd5, 1'b0);
        @(negedge clock);
        check("rej1_pl_ready", {31'h0, pl_ready}, 32'h0);
        check("rej1_pkt_valid", {31'h0, pkt_valid}, 32'h0);
        @(posedge clock);
        #1;
        send(2'd0, 6'd0, 1'b0);
        @(negedge clock);
        check("rej2_pl_ready", {31'h0, pl_ready}, 32'h0);
        check("rej2_pkt_valid", {31'h0, pkt_valid}, 32'h0);
        @(posedge clock);
        #1;
        wait_idle("reject");

`ifdef ROUTER_TX_PARITY_INJECT_EN
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send(2'd1, 6'd3, 1'b1);
        wait_idle("inject");
`endif

        // Maximum length, busy random.
        busy_rand = 1;
        for (int i = 0; i < 63; i++) pay[i] = 8'(i);
        send(2'd2, 6'd63, 1'b0);
        wait_idle("maxlen");

        // Maximum length again, reset while payload byte 30 is on the bus.
        send(2'd2, 6'd63, 1'b0);
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (!(pkt_valid && data_out == 8'd30) && guard < 2000);
        check("reach_byte30", {23'h0, pkt_valid, data_out}, {23'h0, 1'b1, 8'd30});
        #1;
        resetn = 1'b0;
        #1;
        check("async_rst_pkt_valid", {31'h0, pkt_valid}, 32'h0);
        check("async_rst_data_out", {24'h0, data_out}, 32'h0);
        sb.delete();
        repeat (2) @(posedge clock);
        #2;
        resetn = 1'b1;
        @(posedge clock);
        #1;
        pay[0] = 8'hA5; pay[1] = 8'h3C;
        send(2'd0, 6'd2, 1'b0);
        wait_idle("after_reset");

        // Randomised traffic, requests overlapping with transmission.
        pl_gap_pct = 30;
        for (int n = 0; n < 30; n++) begin
            logic [1:0] a;
            logic [5:0] l;
            int         r;
            a = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r == 0)      l = 6'd0;
            else if (r == 1) l = 6'd63;
            else if (r == 2) l = 6'd1;
            else             l = 6'($urandom_range(1, 63));
            for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
            send(a, l, 1'($urandom));
        end
        wait_idle("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter for the 1x3 router input port. Accepts a packet request (destination address, payload length) and the payload bytes from a host, buffers the whole payload, then drives header, payload and parity onto the router's `pkt_valid`/`data_in` bus while honouring the router's `busy` signal. It produces exactly the byte stream the router FSM expects, so benches and upstream logic never hand-sequence packets.

## Interface
Parameters:
- `MAX_LEN`, 63: maximum payload bytes; equals the header length-field range.
- `DATA_W`, 8: bus width. Fixed; header layout depends on it.

Ports:
- `clock`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  packet request valid.
- `req_ready`  out  1  request accepted when both high.
- `req_addr`  in  2  destination port; 0..2 legal.
- `req_len`  in  6  payload length; 1..63 legal.
- `req_err`  out  1  one-cycle pulse: request rejected.
- `pl_valid`  in  1  payload byte valid.
- `pl_ready`  out  1  payload byte accepted when both high.
- `pl_data`  in  8  payload byte.
- `busy`  in  1  router busy; a bus byte is accepted on a rising edge where `busy`==0.
- `pkt_valid`  out  1  router packet valid.
- `data_out`  out  8  router `data_in`.
- `tx_done`  out  1  one-cycle pulse after the parity byte is accepted.

## Operation
- States: IDLE, FILL, HEADER, PAYLOAD, PARITY, GAP.
- IDLE: `req_ready`=1. On handshake, latch addr/len. If addr==3 or len==0: pulse `req_err` next cycle, stay IDLE. Otherwise go to FILL, with parity accumulator = header byte.
- FILL: `pl_ready`=1. Each handshake writes `pl_data` to buffer[idx], idx++, and XORs the byte into parity. After byte len-1, go to HEADER.
- HEADER: `pkt_valid`=1, `data_out`={len,addr} (length in [7:2], address in [1:0]). Go to PAYLOAD on an edge with `busy`==0.
- PAYLOAD: `pkt_valid`=1, `data_out`=buffer[idx]. idx advances only on an edge with `busy`==0. After the last byte is accepted, go to PARITY.
- PARITY: `pkt_valid`=0, `data_out`=parity. On an edge with `busy`==0, go to GAP.
- GAP: one cycle with `pkt_valid`=0 and `data_out`=0. Pulse `tx_done`, then return to IDLE.
- While `busy`=1, `data_out` and `pkt_valid` hold stable. Payload bytes are contiguous; `pkt_valid` never drops mid-payload.
- Reset values: all outputs 0 (including `req_ready`). State IDLE; idx, len, addr and parity cleared. The buffer contents are not reset.
- Reset mid-packet: on assertion, `pkt_valid`/`data_out` go 0 asynchronously and the packet is discarded. There is no resume.

## Timing
- `req_ready` and `pl_ready` are decoded combinationally from the state. All other outputs are registered.
- `req_ready` rises the first cycle after reset release.
- The header is on the bus in the cycle after the edge that accepted the last payload byte.
- With `busy`=0 throughout, a len-N packet occupies N+3 bus cycles (header, N payload, parity, gap), measured from HEADER to IDLE.
- `pl_valid` is ignored outside FILL. `req_valid` is ignored outside IDLE.
- `busy` is sampled only in HEADER, PAYLOAD and PARITY.

## Configuration
- `ROUTER_TX_PARITY_INJECT_EN` defined: adds input `inject_err` (1 bit), latched at request handshake. When the latched value is 1, the transmitted parity byte is bitwise inverted, so the router's parity-check path can be exercised.
- Not defined: the port is absent and parity is always correct.

## Structure
- Shared `router_pkg`: state enum, `MAX_LEN`, address width, header field positions (`HDR_LEN_MSB/LSB`, `HDR_ADDR_MSB/LSB`), and `ADDR_INVALID`=2'd3.
- Sub-module `router_tx_buf`: 64x8 register array with synchronous write and combinational read. It has no reset.

## Test plan
- Reset: hold `resetn`=0 -> all outputs 0. Release -> `req_ready`=1 next cycle; `pkt_valid` stays 0.
- Basic: addr 1, len 3, payload 0x11/0x22/0x33, `busy`=0 -> bus shows 0x0D, 0x11, 0x22, 0x33 with `pkt_valid`=1, then parity 0x0D with `pkt_valid`=0, then a gap cycle and a `tx_done` pulse.
- Stall: same packet, `busy`=1 for 4 cycles while 0x22 is driven -> 0x22 and `pkt_valid`=1 held all 4 cycles; the sequence then resumes unchanged.
- Reject: addr 3 len 5, then addr 0 len 0 -> each gives a one-cycle `req_err`; `pl_ready` stays 0 and `pkt_valid` stays 0.
- Max length and reset: addr 2 len 63, bytes 0..62 -> header 0xFE, 63 payload bytes, parity = 0xFE XOR (XOR of 0..62). Assert `resetn`=0 at payload byte 30 -> `pkt_valid` goes 0 immediately; the next request completes normally.
- Inject (macro on): basic packet with `inject_err`=1 -> parity byte 0xF2.
